// File: rtl/barcode_pkg.sv
// Shared types and constants for the barcode station-ID receiver.
package barcode_pkg;
  typedef enum logic [2:0] {IDLE, MEAS, WAIT_FALL, SAMPLE, DONE} bc_state_t;
  localparam int         ID_BITS = 8;
  localparam logic [1:0] ID_TAG  = 2'b00;
endpackage

// File: rtl/bc_sync_edge.sv
// Two-flop synchroniser for the raw barcode line plus edge detection.
module bc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall,
  output logic rise
);
  logic s1, s2, prev;

  // Preset high so a reset never looks like a falling edge on an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign sync_out = s2;
  assign fall     = prev & ~s2;
  assign rise     = ~prev & s2;
endmodule

// File: rtl/barcode_id_rx.sv
// Self-timed barcode decoder: start pulse sets bit period, 8 bits MSB first,
// legal IDs are published on the ID / ID_vld / clr_ID_vld handshake.
module barcode_id_rx
  import barcode_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int MIN_T = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               BC,
  input  logic               clr_ID_vld,
  output logic [ID_BITS-1:0] ID,
  output logic               ID_vld
);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_T);

  bc_state_t          state;
  logic [CNT_W-1:0]   period, timer, half, lim;
  logic [2:0]         bit_cnt;
  logic [ID_BITS-1:0] shift;
  logic               bc, fall, rise;

  bc_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (BC),
    .sync_out (bc),
    .fall     (fall),
    .rise     (rise)
  );

  assign half = period >> 1;
  // Two-period gap limit, clamped so it cannot wrap for very long pulses.
  assign lim  = period[CNT_W-1] ? '1 : (period << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ID      <= '0;
      ID_vld  <= 1'b0;
      period  <= '0;
      timer   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (clr_ID_vld) ID_vld <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state  <= MEAS;
          period <= ONE;
        end
        MEAS: begin
          if (rise) begin
            if (period < MIN_P) state <= IDLE;
            else begin
              state   <= WAIT_FALL;
              bit_cnt <= '0;
              timer   <= '0;
            end
          end else if (&period) state <= IDLE;
          else period <= period + ONE;
        end
        WAIT_FALL: begin
          if (fall) begin
            state <= SAMPLE;
            timer <= ONE;
          end else if (timer >= lim) state <= IDLE;
          else timer <= timer + ONE;
        end
        SAMPLE: begin
          if (timer == half) begin
            shift   <= {shift[ID_BITS-2:0], bc};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(ID_BITS - 1)) state <= DONE;
            else begin
              state <= WAIT_FALL;
              timer <= '0;
            end
          end else if (!(&timer)) timer <= timer + ONE;
        end
        DONE: begin
          state <= IDLE;
          // Set beats a same-cycle clear; untagged codes are dropped silently.
          if (shift[ID_BITS-1 -: 2] == ID_TAG) begin
            ID     <= shift;
            ID_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barcode_id_rx.sv
// Scoreboard bench: legal frames push expected ID and publish cycle; a
// monitor pops on every ID_vld rise.
module tb_barcode_id_rx;
  localparam int T    = 400;
  localparam int HALF = T / 2;

  typedef struct {
    logic [7:0] id;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, BC, clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   clr_on = 0, clr_off = 0;
  logic vld_q = 1'b0;
  exp_t exp_q[$];
  exp_t e;

  barcode_id_rx #(.CNT_W(22), .MIN_T(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ID_vld === 1'b1 && !vld_q) begin
      if (exp_q.size() == 0) chk("unexp_vld", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("id", {24'd0, ID}, {24'd0, e.id});
        chk("latency", cyc, e.due);
      end
    end
    vld_q = (ID_vld === 1'b1);
  end

  task automatic step(input logic v);
    @(negedge clk);
    BC         = v;
    clr_ID_vld = (cyc >= clr_on && cyc < clr_off);
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic pulse_clr();
    clr_on     = cyc;
    clr_off    = cyc + 1;
    clr_ID_vld = 1'b1;
    step(1'b1);
  endtask

  // Bit 1 = short low, bit 0 = long low; abort_bit >= 0 resets mid-bit.
  task automatic send_frame(input logic [7:0] id, input bit clr_done, input int abort_bit);
    int lo, k;
    drive(1'b0, T);
    drive(1'b1, 100);
    for (int i = 7; i >= 0; i--) begin
      lo = id[i] ? 100 : 300;
      if (i == abort_bit) begin
        drive(1'b0, 50);
        rst = 1'b1;
        drive(1'b1, 2);
        rst = 1'b0;
        drive(1'b1, 300);
        return;
      end
      step(1'b0);
      if (i == 0) begin
        k = cyc;
        if (id[7:6] == 2'b00) exp_q.push_back('{id, k + HALF + 4});
        if (clr_done) begin
          clr_on  = k + HALF + 1;
          clr_off = k + HALF + 4;
        end
      end
      drive(1'b0, lo - 1);
      drive(1'b1, T - lo);
    end
    drive(1'b1, 300);
  endtask

  initial begin
    int bad;
    BC = 1'b1; clr_ID_vld = 1'b0; rst = 1'b1;
    drive(1'b1, 2);
    rst = 1'b0;
    chk("rst_id", {24'd0, ID}, 32'h00);
    chk("rst_vld", {31'd0, ID_vld}, 0);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1);
      if (ID_vld !== 1'b0 || ID !== 8'h00) bad++;
    end
    chk("idle_quiet", bad, 0);

    send_frame(8'h2A, 1'b0, -1);
    chk("vld_2a", {31'd0, ID_vld}, 1);
    pulse_clr();
    chk("clr_vld", {31'd0, ID_vld}, 0);
    chk("clr_id_kept", {24'd0, ID}, 32'h2A);

    send_frame(8'hC5, 1'b0, -1);
    chk("bad_tag_id", {24'd0, ID}, 32'h2A);
    chk("bad_tag_vld", {31'd0, ID_vld}, 0);

    drive(1'b0, 2);
    drive(1'b1, 200);
    chk("glitch_vld", {31'd0, ID_vld}, 0);
    chk("glitch_id", {24'd0, ID}, 32'h2A);

    drive(1'b0, T);
    drive(1'b1, 2000);
    chk("timeout_vld", {31'd0, ID_vld}, 0);
    send_frame(8'h11, 1'b0, -1);
    chk("vld_11", {31'd0, ID_vld}, 1);
    pulse_clr();
    chk("clr_11", {31'd0, ID_vld}, 0);

    send_frame(8'h07, 1'b1, -1);
    chk("setclr_vld", {31'd0, ID_vld}, 1);
    chk("setclr_id", {24'd0, ID}, 32'h07);

    send_frame(8'h3F, 1'b0, 3);
    chk("abort_id", {24'd0, ID}, 32'h00);
    chk("abort_vld", {31'd0, ID_vld}, 0);

    send_frame(8'h15, 1'b0, -1);
    chk("vld_15", {31'd0, ID_vld}, 1);
    chk("id_15", {24'd0, ID}, 32'h15);

    chk("pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
